// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: fetch-stage PC with boot/run/halt sequencing, next-PC select, error flags and retire count.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          IMEM_AW  = 10
) (
    input  logic        CLK,
    input  logic        RST_n,
    input  logic        PCWre,
    input  logic [1:0]  PCSrc,
    input  logic [15:0] immediate,
    input  logic [25:0] targe,
    input  logic [31:0] jr_addr,
    input  logic        halt_req,
    output logic [31:0] IAddr,
    output logic [31:0] pc_plus4,
    output logic        running,
    output logic        halted,
    output logic        err_misalign,
    output logic        err_range,
    output logic [31:0] instr_cnt
);
    typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;
    state_t state, state_nx;
    logic [31:0] next_pc;
    logic [31:0] br_off;
    logic        upd;
    logic        oor;
    always_comb begin
        pc_plus4 = IAddr + 32'd4;
        br_off   = {{14{immediate[15]}}, immediate, 2'b00};
        next_pc  = PCSrc == 2'b00 ? pc_plus4 :
                   PCSrc == 2'b01 ? pc_plus4 + br_off :
                   PCSrc == 2'b10 ? {pc_plus4[31:28], targe, 2'b00} :
                                    {jr_addr[31:2], 2'b00};
        oor      = next_pc[31:IMEM_AW+2] != '0;
        upd      = state == RUN && PCWre && !halt_req;
    end
    // BOOT lasts exactly one edge; HALT is only left through reset.
    always_comb begin
        state_nx = state == BOOT ? RUN :
                   (state == RUN && halt_req) ? HALT : state;
    end
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) state <= BOOT;
        else        state <= state_nx;
    end
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            IAddr        <= RESET_PC;
            instr_cnt    <= '0;
            running      <= 1'b0;
            halted       <= 1'b0;
            err_misalign <= 1'b0;
            err_range    <= 1'b0;
        end else begin
            running      <= state_nx == RUN;
            halted       <= state_nx == HALT;
            err_misalign <= err_misalign | (upd && PCSrc == 2'b11 && jr_addr[1:0] != 2'b00);
            err_range    <= err_range | (upd && oor);
            if (upd) begin
                IAddr     <= next_pc;
                instr_cnt <= instr_cnt + 32'd1;
            end
        end
    end
endmodule
